// File: rtl/perm_engine.sv
// -----------------------------------------------------------------------------
// perm_engine
//   Bit permutation engine with a programmable map and a map validator.
//   Forward mode:  out_data[j]      = in_data[map[j]]
//   Inverse mode:  out_data[map[j]] = in_data[j]
//   The map is written one entry at a time while idle. A commit runs a
//   WIDTH-cycle scan proving the map is a bijection on 1..WIDTH. Words are
//   only accepted while the map is proven good.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset (identity map, map_ok=1)
//   in_valid    input word offered
//   in_ready    engine accepts the word this cycle
//   in_data     word to permute, bits [WIDTH:1]
//   mode        0 = forward, 1 = inverse, sampled with the accepted word
//   out_valid   out_data holds a result
//   out_ready   consumer takes the result
//   out_data    permuted word, bits [WIDTH:1]
//   cfg_we      write map[cfg_addr] = cfg_data (idle only)
//   cfg_addr    destination position 1..WIDTH, other values ignored
//   cfg_data    source bit number for that position
//   cfg_commit  start map validation (idle only)
//   busy        validation scan in progress
//   map_ok      map is a proven bijection on 1..WIDTH
//
// State   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | accepts map writes / commit; data path runs when map_ok
// S_CHECK | scanning one map entry per cycle; config inputs ignored
// -----------------------------------------------------------------------------
module perm_engine #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:1]   in_data,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:1]   out_data,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [IDX_W-1:0] cfg_data,
  input  logic             cfg_commit,
  output logic             busy,
  output logic             map_ok
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CHECK = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [IDX_W-1:0] r_map [1:WIDTH];
  logic [IDX_W-1:0] r_cnt;
  logic [WIDTH:1]   r_seen;
  logic             r_err;
  logic             r_map_ok;
  logic             r_out_valid;
  logic [WIDTH:1]   r_out_data;

  logic             w_addr_ok;
  logic [IDX_W-1:0] w_entry;
  logic             w_dup;
  logic             w_entry_bad;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH:1]   w_perm_fwd;
  logic [WIDTH:1]   w_perm_inv;

  // ---------------------------------------------------------------------------
  // Status and handshake
  // ---------------------------------------------------------------------------
  assign busy      = (r_state == S_CHECK);
  assign map_ok    = r_map_ok;
  assign in_ready  = !busy && r_map_ok && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  assign w_addr_ok = (cfg_addr != '0) && (cfg_addr <= IDX_W'(WIDTH));

  // ---------------------------------------------------------------------------
  // Scan datapath: r_cnt counts entries already examined, so the entry under
  // test this cycle is map[r_cnt+1].
  // ---------------------------------------------------------------------------
  always_comb begin
    w_entry = '0;
    for (int j = 1; j <= WIDTH; j++) begin
      if (r_cnt == IDX_W'(j - 1)) w_entry = r_map[j];
    end
  end

  always_comb begin
    w_dup = 1'b0;
    for (int k = 1; k <= WIDTH; k++) begin
      if ((w_entry == IDX_W'(k)) && r_seen[k]) w_dup = 1'b1;
    end
  end

  assign w_entry_bad = (w_entry == '0) || (w_entry > IDX_W'(WIDTH)) || w_dup;
  assign w_last      = (r_cnt == IDX_W'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cfg_commit) w_state_nxt = S_CHECK;
      S_CHECK: if (w_last)     w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Map storage, scan counter, seen mask and verdict.
  // A write and a commit on the same edge both act: the entry lands now and
  // the scan reads the registered map from the next cycle, so it sees it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 1; j <= WIDTH; j++) r_map[j] <= IDX_W'(j);
      r_map_ok <= 1'b1;
      r_cnt    <= '0;
      r_seen   <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_we && w_addr_ok) begin
            for (int j = 1; j <= WIDTH; j++) begin
              if (cfg_addr == IDX_W'(j)) r_map[j] <= cfg_data;
            end
            r_map_ok <= 1'b0;
          end
          if (cfg_commit) begin
            r_map_ok <= 1'b0;
            r_cnt    <= '0;
            r_seen   <= '0;
            r_err    <= 1'b0;
          end
        end
        S_CHECK: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_entry_bad) begin
            r_err <= 1'b1;
          end else begin
            for (int k = 1; k <= WIDTH; k++) begin
              if (w_entry == IDX_W'(k)) r_seen[k] <= 1'b1;
            end
          end
          // The last entry's verdict is folded in directly since r_err
          // would only reflect it one cycle later.
          if (w_last) r_map_ok <= !(r_err || w_entry_bad);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Permutation networks. Written as compare-and-select so out-of-range map
  // values (possible only while map_ok=0) never index outside the word.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_perm_fwd = '0;
    w_perm_inv = '0;
    for (int j = 1; j <= WIDTH; j++) begin
      for (int k = 1; k <= WIDTH; k++) begin
        if (r_map[j] == IDX_W'(k)) begin
          w_perm_fwd[j] = in_data[k];
          w_perm_inv[k] = in_data[j];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: one-deep, full throughput when the consumer keeps up.
  // A held result drains normally regardless of configuration activity.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= mode ? w_perm_inv : w_perm_fwd;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_perm_engine.sv
// -----------------------------------------------------------------------------
// tb_perm_engine
//   Table-driven vectors plus hand-written sequences for configuration,
//   validation, backpressure and reset-during-scan. A scoreboard queue holds
//   the expected word for every accepted input and is checked whenever the
//   engine hands a word to the consumer.
// -----------------------------------------------------------------------------
module tb_perm_engine;

  localparam int W  = 32;
  localparam int IW = 6;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W:1]    in_data;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [W:1]    out_data;
  logic          cfg_we;
  logic [IW-1:0] cfg_addr;
  logic [IW-1:0] cfg_data;
  logic          cfg_commit;
  logic          busy;
  logic          map_ok;

  int n_cmp;
  int n_bad;

  int tb_map [1:W];
  int des_p [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                      2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  logic [W:1] sb [$];

  typedef struct {
    logic [W:1] data;
    logic       mode;
    logic [W:1] exp;
  } vec_t;

  vec_t tv [10];

  perm_engine #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_commit(cfg_commit),
    .busy      (busy),
    .map_ok    (map_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1, "timeout");
  end

  function automatic logic [W:1] bit1(input int k);
    logic [W:1] r;
    r    = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [W:1] model(input logic [W:1] d, input logic m);
    logic [W:1] r;
    r = '0;
    for (int j = 1; j <= W; j++) begin
      if (!m) r[j]         = d[tb_map[j]];
      else    r[tb_map[j]] = d[j];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W:1] act, input logic [W:1] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_scan(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_valid = 1'b1;
      in_data  = tv[i].data;
      mode     = tv[i].mode;
      tick();
      chk($sformatf("vec%0d_valid", i), W'(out_valid), W'(1));
      chk($sformatf("vec%0d_data", i), out_data, tv[i].exp);
    end
    in_valid = 1'b0;
    tick();
  endtask

  // Scoreboard: compare before pushing so a word accepted on the same edge
  // as a drain never gets compared against itself.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got %h, required no output", out_data);
        end else begin
          chk("sb_out", out_data, sb.pop_front());
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_data, mode));
    end
  end

  initial begin
    int n;

    n_cmp = 0;
    n_bad = 0;

    tv[0] = '{data: 32'hA5A5_0F0F, mode: 1'b0, exp: 32'hA5A5_0F0F};
    tv[1] = '{data: 32'h8000_0001, mode: 1'b1, exp: 32'h8000_0001};
    tv[2] = '{data: bit1(16),            mode: 1'b0, exp: bit1(1)};
    tv[3] = '{data: bit1(1),             mode: 1'b1, exp: bit1(16)};
    tv[4] = '{data: bit1(16) | bit1(7),  mode: 1'b0, exp: bit1(1) | bit1(2)};
    tv[5] = '{data: bit1(1),             mode: 1'b0, exp: bit1(9)};
    tv[6] = '{data: bit1(9),             mode: 1'b1, exp: bit1(1)};
    tv[7] = '{data: bit1(25),            mode: 1'b0, exp: bit1(32)};
    tv[8] = '{data: bit1(32),            mode: 1'b1, exp: bit1(25)};
    tv[9] = '{data: 32'hFFFF_FFFF,       mode: 1'b0, exp: 32'hFFFF_FFFF};

    for (int j = 1; j <= W; j++) tb_map[j] = j;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    mode       = 1'b0;
    out_ready  = 1'b1;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    cfg_commit = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_busy",     W'(busy),      W'(0));
    chk("rst_map_ok",   W'(map_ok),    W'(1));
    chk("rst_out_valid",W'(out_valid), W'(0));
    chk("rst_out_data", out_data,      '0);
    chk("rst_in_ready", W'(in_ready),  W'(1));

    // Identity map: bit 5 straight through, latency one
    in_valid = 1'b1;
    in_data  = bit1(5);
    mode     = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("id_bit5_valid", W'(out_valid), W'(1));
    chk("id_bit5_data",  out_data,      bit1(5));
    tick();
    chk("id_drain_valid", W'(out_valid), W'(0));

    run_vecs(0, 1);

    // Load DES P; last write shares the edge with the commit
    for (int j = 1; j <= W; j++) begin
      cfg_we     = 1'b1;
      cfg_addr   = IW'(j);
      cfg_data   = IW'(des_p[j-1]);
      cfg_commit = (j == W);
      tb_map[j]  = des_p[j-1];
      tick();
      if (j == 1) chk("cfg_clears_ok", W'(map_ok), W'(0));
    end
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
    chk("scan_in_ready", W'(in_ready), W'(0));
    wait_scan(n);
    chk("des_scan_len", W'(n),      W'(32));
    chk("des_map_ok",   W'(map_ok), W'(1));

    run_vecs(2, 9);

    // Duplicate entry: map[2]=16 collides with map[1]
    cfg_we   = 1'b1;
    cfg_addr = IW'(2);
    cfg_data = IW'(16);
    tb_map[2] = 16;
    tick();
    cfg_we     = 1'b0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    wait_scan(n);
    chk("dup_scan_len", W'(n),      W'(32));
    chk("dup_map_ok",   W'(map_ok), W'(0));
    in_valid = 1'b1;
    in_data  = bit1(3);
    mode     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("dup_in_ready", W'(in_ready), W'(0));
      tick();
      chk("dup_no_output", W'(out_valid), W'(0));
    end
    in_valid = 1'b0;

    // Repair with write+commit on the same edge
    cfg_we     = 1'b1;
    cfg_addr   = IW'(2);
    cfg_data   = IW'(7);
    cfg_commit = 1'b1;
    tb_map[2]  = 7;
    tick();
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
    wait_scan(n);
    chk("fix_map_ok", W'(map_ok), W'(1));

    // Backpressure: A held for 3 cycles while B waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = bit1(16);
    mode      = 1'b0;
    tick();
    in_data = bit1(1);
    mode    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_in_ready", W'(in_ready),  W'(0));
      chk("bp_valid",    W'(out_valid), W'(1));
      chk("bp_stable",   out_data,      bit1(1));
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_b_valid", W'(out_valid), W'(1));
    chk("bp_b_data",  out_data,      bit1(16));
    tick();
    chk("bp_empty", W'(out_valid), W'(0));

    // Held word drains during a scan; a write during the scan is ignored
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_data    = bit1(7);
    mode       = 1'b0;
    cfg_commit = 1'b1;
    tick();
    in_valid   = 1'b0;
    cfg_commit = 1'b0;
    chk("drain_busy",  W'(busy),      W'(1));
    chk("drain_valid", W'(out_valid), W'(1));
    chk("drain_data",  out_data,      bit1(2));
    out_ready = 1'b1;
    tick();
    chk("drain_done", W'(out_valid), W'(0));
    repeat (2) tick();
    cfg_we     = 1'b1;
    cfg_addr   = IW'(1);
    cfg_data   = '0;
    cfg_commit = 1'b1;
    tick();
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
    wait_scan(n);
    chk("ign_scan_rest", W'(n),      W'(28));
    chk("ign_map_ok",    W'(map_ok), W'(1));
    run_vecs(2, 2);

    // Reset in the middle of a scan with a word held at the output
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_data    = bit1(1);
    mode       = 1'b0;
    cfg_commit = 1'b1;
    tick();
    in_valid   = 1'b0;
    cfg_commit = 1'b0;
    repeat (9) tick();
    chk("pre_rst_busy",  W'(busy),      W'(1));
    chk("pre_rst_valid", W'(out_valid), W'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy",   W'(busy),      W'(0));
    chk("mid_rst_map_ok", W'(map_ok),    W'(1));
    chk("mid_rst_valid",  W'(out_valid), W'(0));
    chk("mid_rst_data",   out_data,      '0);
    sb.delete();
    for (int j = 1; j <= W; j++) tb_map[j] = j;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    in_valid = 1'b1;
    in_data  = bit1(16);
    mode     = 1'b0;
    tick();
    chk("post_rst_identity16", out_data, bit1(16));
    in_data = bit1(5);
    tick();
    in_valid = 1'b0;
    chk("post_rst_identity5", out_data, bit1(5));
    tick();

    chk("sb_drained", W'(sb.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
